// File: rtl/imem_loader_if.sv
// Byte-stream receive port and instruction-memory write port
// bundled for the boot loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream to little-endian instruction
// words, holding the core in reset until a frame verifies.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_rst_n
);
    localparam int IW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        SYNC, COUNT, DATA, CHECK, DONE, ERR
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q;
    logic [IW-1:0]   idx_q;
    logic [1:0]      lane_q;
    logic [7:0]      csum_q;
    logic [23:0]     asm_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;

    logic xfer;
    logic last_word;
    logic bad_count;

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign last_word = ({24'd0, cnt_q} == 32'(idx_q) + 32'd1);
    assign bad_count = (bus.rx_data == 8'd0) ||
                       ({24'd0, bus.rx_data} > 32'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SYNC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC: begin
                if (xfer && bus.rx_data == 8'hA5)
                    state_d = COUNT;
            end
            COUNT: begin
                if (xfer)
                    state_d = bad_count ? ERR : DATA;
            end
            DATA: begin
                if (xfer && lane_q == 2'd3 && last_word)
                    state_d = CHECK;
            end
            CHECK: begin
                if (xfer)
                    state_d = (bus.rx_data == csum_q) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (start)
                    state_d = SYNC;
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        bus.rx_ready = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            SYNC: bus.rx_ready = 1'b1;
            COUNT, DATA, CHECK: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
            end
            default: ;
        endcase
        done      = (state_q == DONE);
        err       = (state_q == ERR);
        cpu_rst_n = done;
    end

    // Lanes 0..2 park in asm_q; lane 3 completes the word directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            csum_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (xfer) begin
                unique case (state_q)
                    COUNT: begin
                        cnt_q  <= bus.rx_data;
                        idx_q  <= '0;
                        lane_q <= '0;
                        csum_q <= '0;
                    end
                    DATA: begin
                        csum_q <= csum_q ^ bus.rx_data;
                        lane_q <= lane_q + 2'd1;
                        unique case (lane_q)
                            2'd0: asm_q[7:0]   <= bus.rx_data;
                            2'd1: asm_q[15:8]  <= bus.rx_data;
                            2'd2: asm_q[23:16] <= bus.rx_data;
                            default: begin
                                we_q    <= 1'b1;
                                wdata_q <= {bus.rx_data, asm_q};
                                addr_q  <= {{(30-IW){1'b0}}, idx_q, 2'b00};
                                idx_q   <= idx_q + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, bad counts,
// stalls and mid-frame reset.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err, cpu_rst_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] fw[$];

    imem_loader_if bus();

    imem_loader #(.DEPTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        t = 0;
        while (!bus.rx_ready && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("rx_ready", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input bit bad_cs, input bit gaps);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send(8'hA5, 0);
        send(8'(fw.size()), 0);
        foreach (fw[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = fw[i][8*k +: 8];
                cs ^= b;
                send(b, gaps ? int'($urandom_range(0, 2)) : 0);
            end
        end
        send(bad_cs ? 8'h00 : cs, 0);
        idle();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 32'(wa.size()), 32'(fw.size()));
        foreach (fw[i]) begin
            if (i < wa.size()) begin
                chk({tag, "_addr"}, wa[i], 32'(i * 4));
                chk({tag, "_data"}, wd[i], fw[i]);
            end
        end
        wa.delete();
        wd.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // XOR of the eight data bytes is 0x21
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h93, 0); send(8'h00, 0);
        send(8'h10, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h01, 0);
        send(8'hB0, 0); send(8'h00, 0);
        send(8'h21, 0);
        idle();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_rx_ready", 32'(bus.rx_ready), 32'd0);
        fw = '{32'h00100093, 32'h00B00113};
        check_writes("t1");
        pulse_start();
        chk("t1_rearm_done", 32'(done), 32'd0);
        chk("t1_rearm_cpu", 32'(cpu_rst_n), 32'd0);
        chk("t1_rearm_ready", 32'(bus.rx_ready), 32'd1);

        send_frame(1'b1, 1'b0);
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("t2_rx_ready", 32'(bus.rx_ready), 32'd0);
        check_writes("t2");
        pulse_start();
        chk("t2_rearm_err", 32'(err), 32'd0);

        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h5A, 0);
        idle();
        chk("t3_garbage_busy", 32'(busy), 32'd0);
        fw = '{32'h00000537};
        send_frame(1'b0, 1'b0);
        chk("t3_done", 32'(done), 32'd1);
        check_writes("t3");
        pulse_start();

        send(8'hA5, 0);
        send(8'h00, 0);
        idle();
        chk("t4a_err", 32'(err), 32'd1);
        chk("t4a_busy", 32'(busy), 32'd0);
        chk("t4a_writes", 32'(wa.size()), 32'd0);
        pulse_start();
        chk("t4a_rearm_err", 32'(err), 32'd0);
        chk("t4a_rearm_ready", 32'(bus.rx_ready), 32'd1);

        send(8'hA5, 0);
        send(8'd65, 0);
        idle();
        chk("t4b_err", 32'(err), 32'd1);
        chk("t4b_writes", 32'(wa.size()), 32'd0);
        pulse_start();
        chk("t4b_rearm_err", 32'(err), 32'd0);
        chk("t4b_rearm_ready", 32'(bus.rx_ready), 32'd1);

        fw.delete();
        for (int i = 0; i < 64; i++)
            fw.push_back({8'(i) ^ 8'hA5, 8'hC3, 8'(i * 3), ~8'(i)});
        send_frame(1'b0, 1'b1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_err", 32'(err), 32'd0);
        check_writes("t5");
        pulse_start();

        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h93, 0); send(8'h00, 0);
        send(8'h10, 0); send(8'h00, 0);
        send(8'h13, 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("t6_midreset");
        @(negedge clk);
        rst_n = 1'b1;
        wa.delete();
        wd.delete();
        fw = '{32'h00100093, 32'h00B00113};
        send_frame(1'b0, 1'b0);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check_writes("t6");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
